// File: rtl/logdrop_window_seq.sv
// Logdrop windowing sequencer: handshakes samples, applies the window coefficient
// and accumulates each complete window into a sum on a separate valid/ready port.

module logdropWindow #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned WINLEN         = 64,
    parameter int unsigned ABSTRACT_MODEL = 0
) (
    input  logic [$clog2(WINLEN)-1:0] i_t,
    input  logic [DATA_W-1:0]         i_x,
    output logic [DATA_W-1:0]         o_y
);
    localparam int unsigned WINLEN_W  = $clog2(WINLEN);
    localparam int unsigned HALF_LOG2 = WINLEN_W - 1;

    if (ABSTRACT_MODEL != 0) begin : gAbstract
        always_comb begin
            int unsigned distance;
            int unsigned ceilLog;
            if (32'(i_t) < WINLEN / 2) begin
                distance = 32'(i_t) + 1;
            end else begin
                distance = WINLEN - 32'(i_t);
            end
            ceilLog = 0;
            for (int unsigned k = 0; k < WINLEN_W; k++) begin
                if ((32'd1 << ceilLog) < distance) begin
                    ceilLog = ceilLog + 1;
                end
            end
            o_y = i_x >> (HALF_LOG2 - ceilLog);
        end
    end else begin : gStructural
        // Folding t about the centre gives min(t+1, WINLEN-t)-1; its bit length is the ceil-log2.
        logic [WINLEN_W-2:0] folded;
        logic [WINLEN_W-1:0] bitLen;

        always_comb begin
            folded = i_t[WINLEN_W-1] ? ~i_t[WINLEN_W-2:0] : i_t[WINLEN_W-2:0];
            bitLen = '0;
            for (int unsigned k = 0; k < WINLEN_W - 1; k++) begin
                if (folded[k]) begin
                    bitLen = WINLEN_W'(k + 1);
                end
            end
            o_y = i_x >> (WINLEN_W'(HALF_LOG2) - bitLen);
        end
    end
endmodule

module logdrop_window_seq #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned WINLEN         = 64,
    parameter int unsigned ABSTRACT_MODEL = 0
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic                                 i_en,
    input  logic                                 i_xValid,
    output logic                                 o_xReady,
    input  logic [DATA_W-1:0]                    i_x,
    output logic [$clog2(WINLEN)-1:0]            o_t,
    output logic                                 o_yValid,
    output logic [DATA_W-1:0]                    o_y,
    output logic [$clog2(WINLEN)-1:0]            o_yT,
    output logic                                 o_sumValid,
    input  logic                                 i_sumReady,
    output logic [DATA_W+$clog2(WINLEN)-1:0]     o_sum
);
    localparam int unsigned WINLEN_W = $clog2(WINLEN);
    localparam int unsigned SUM_W    = DATA_W + WINLEN_W;
    localparam logic [WINLEN_W-1:0] LAST_T = WINLEN_W'(WINLEN - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    state_t             stateNext;
    logic [SUM_W-1:0]   acc;
    logic [DATA_W-1:0]  yWin;
    logic               lastT;
    logic               accept;

    logdropWindow #(
        .DATA_W        (DATA_W),
        .WINLEN        (WINLEN),
        .ABSTRACT_MODEL(ABSTRACT_MODEL)
    ) uWindow (
        .i_t(o_t),
        .i_x(i_x),
        .o_y(yWin)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (i_en)  stateNext = RUN;
            RUN:     if (!i_en) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // The closing sample of a window waits only while the previous sum is still unclaimed.
    always_comb begin
        lastT    = (o_t == LAST_T);
        o_xReady = (state == RUN) && i_en && !(lastT && o_sumValid && !i_sumReady);
        accept   = i_xValid && o_xReady;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_t        <= '0;
            acc        <= '0;
            o_y        <= '0;
            o_yT       <= '0;
            o_yValid   <= 1'b0;
            o_sum      <= '0;
            o_sumValid <= 1'b0;
        end else begin
            o_yValid <= accept;
            if (accept) begin
                o_y  <= yWin;
                o_yT <= o_t;
            end

            if (o_sumValid && i_sumReady) begin
                o_sumValid <= 1'b0;
            end

            if (!i_en) begin
                o_t <= '0;
                acc <= '0;
            end else if (accept) begin
                o_t <= o_t + 1'b1;
                if (lastT) begin
                    o_sum      <= acc + SUM_W'(yWin);
                    o_sumValid <= 1'b1;
                    acc        <= '0;
                end else begin
                    acc <= acc + SUM_W'(yWin);
                end
            end
        end
    end
endmodule
